// File: rtl/regfile_wr_arb_if.sv
// Bundles the writeback/long-latency/issue inputs and the register-file write outputs of regfile_wr_arb.
// "master" drives results and issue events; "slave" is the arbiter.
interface regfile_wr_arb_if;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        issue_set;
  logic [4:0]  issue_rd;
  logic [31:0] pend;
  logic        pipe_hold;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport master (
    output wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data, issue_set, issue_rd,
    input  lu_ready, pend, pipe_hold, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data, issue_set, issue_rd,
    output lu_ready, pend, pipe_hold, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_wr_arb.sv
// Register-file write-port arbiter: writeback has priority, long-latency results queue in a small FIFO,
// a pending-register scoreboard tracks outstanding long-latency destinations, and starvation raises pipe_hold.
module regfile_wr_arb #(
  parameter int unsigned BUF_DEPTH  = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic              clk,
  input logic              rst_n,
  regfile_wr_arb_if.slave  bus
);
  localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned SW = (STARVE_MAX > 2) ? $clog2(STARVE_MAX) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(BUF_DEPTH);
  localparam logic [SW-1:0] SAT_C   = SW'(STARVE_MAX - 1);
  localparam logic [SW-1:0] HOLD_C  = SW'(STARVE_MAX - 2);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } lu_entry_t;

  lu_entry_t     mem_q [BUF_DEPTH];
  lu_entry_t     head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   pend_q, pend_d;
  logic          pipe_hold_q, pipe_hold_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic          empty, full, push, pop, blocked;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign head    = mem_q[rd_ptr_q];
  assign push    = bus.lu_valid && bus.lu_ready;
  assign pop     = !bus.wb_valid && !empty;
  assign blocked = bus.wb_valid && !empty;

  assign bus.lu_ready  = rst_n && !full;
  assign bus.pend      = pend_q;
  assign bus.pipe_hold = pipe_hold_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (bus.wb_valid) begin
      rf_we_d    = (bus.wb_rd != 5'd0);
      rf_waddr_d = bus.wb_rd;
      rf_wdata_d = bus.wb_data;
    end else if (pop) begin
      rf_we_d    = (head.rd != 5'd0);
      rf_waddr_d = head.rd;
      rf_wdata_d = head.data;
    end

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // Saturate while blocked; pipe_hold fires on the edge reaching the limit and again if WB keeps winning.
    starve_d    = blocked ? ((starve_q == SAT_C) ? starve_q : starve_q + SW'(1)) : '0;
    pipe_hold_d = blocked && (starve_q >= HOLD_C);

    // Clear before set so a same-register set on the same edge wins.
    pend_d = pend_q;
    if (pop)           pend_d[head.rd]      = 1'b0;
    if (bus.issue_set) pend_d[bus.issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      pend_q      <= '0;
      pipe_hold_q <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_d;
      starve_q    <= starve_d;
      pend_q      <= pend_d;
      pipe_hold_q <= pipe_hold_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count_q gates every read, so stale entries are never used.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{rd: bus.lu_rd, data: bus.lu_data};
  end
endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed bench for regfile_wr_arb: reset, single long-latency op, WB contention, full FIFO/starvation,
// r0 suppression with set/clear race, and mid-flight reset.
module tb_regfile_wr_arb;
  localparam int unsigned BUF_DEPTH  = 2;
  localparam int unsigned STARVE_MAX = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  regfile_wr_arb_if bus ();

  regfile_wr_arb #(.BUF_DEPTH(BUF_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.lu_valid  = 1'b0;
    bus.lu_rd     = '0;
    bus.lu_data   = '0;
    bus.issue_set = 1'b0;
    bus.issue_rd  = '0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 5'd3;
    bus.wb_data   = 32'h1234;
    bus.lu_valid  = 1'b1;
    bus.lu_rd     = 5'd4;
    bus.lu_data   = 32'h5678;
    bus.issue_set = 1'b1;
    bus.issue_rd  = 5'd6;
    step();
    step();
    checks++; if (bus.lu_ready !== 1'b0) begin failures++; $display("FAIL reset_lu_ready got=%0b exp=0", bus.lu_ready); end
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0b exp=0", bus.rf_we); end
    checks++; if (bus.pend !== 32'h0) begin failures++; $display("FAIL reset_pend got=%h exp=0", bus.pend); end
    checks++; if (bus.pipe_hold !== 1'b0) begin failures++; $display("FAIL reset_pipe_hold got=%0b exp=0", bus.pipe_hold); end
    checks++; if (bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'h0) begin failures++; $display("FAIL reset_rf_addr_data got=%0d/%h exp=0/0", bus.rf_waddr, bus.rf_wdata); end
    idle_inputs();
    rst_n = 1'b1;
    step();
    checks++; if (bus.lu_ready !== 1'b1) begin failures++; $display("FAIL release_lu_ready got=%0b exp=1", bus.lu_ready); end
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL release_rf_we got=%0b exp=0", bus.rf_we); end
  endtask

  task automatic test_single();
    bus.issue_set = 1'b1;
    bus.issue_rd  = 5'd5;
    step();
    bus.issue_set = 1'b0;
    checks++; if (bus.pend !== 32'h0000_0020) begin failures++; $display("FAIL single_pend_set got=%h exp=00000020", bus.pend); end
    bus.lu_valid = 1'b1;
    bus.lu_rd    = 5'd5;
    bus.lu_data  = 32'hDEAD_BEEF;
    step();
    bus.lu_valid = 1'b0;
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL single_accept_rf_we got=%0b exp=0", bus.rf_we); end
    step();
    checks++; if (bus.rf_we !== 1'b1) begin failures++; $display("FAIL single_rf_we got=%0b exp=1", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd5) begin failures++; $display("FAIL single_rf_waddr got=%0d exp=5", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rf_wdata got=%h exp=deadbeef", bus.rf_wdata); end
    checks++; if (bus.pend !== 32'h0) begin failures++; $display("FAIL single_pend_clear got=%h exp=0", bus.pend); end
    step();
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL single_idle_rf_we got=%0b exp=0", bus.rf_we); end
  endtask

  task automatic test_contention();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd3;
    bus.wb_data  = 32'h11;
    bus.lu_valid = 1'b1;
    bus.lu_rd    = 5'd7;
    bus.lu_data  = 32'h22;
    step();
    idle_inputs();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'h11)
      begin failures++; $display("FAIL contention_wb got=%0b/%0d/%h exp=1/3/11", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    step();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 32'h22)
      begin failures++; $display("FAIL contention_lu got=%0b/%0d/%h exp=1/7/22", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    step();
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL contention_idle got=%0b exp=0", bus.rf_we); end
  endtask

  task automatic test_full();
    logic exp_hold;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    bus.wb_data  = 32'hA0;
    bus.lu_valid = 1'b1;
    bus.lu_rd    = 5'd10;
    bus.lu_data  = 32'h1010;
    step();
    bus.lu_rd   = 5'd11;
    bus.lu_data = 32'h1111;
    step();  // first blocked edge, FIFO now holds BUF_DEPTH entries
    bus.lu_valid = 1'b0;
    checks++; if (bus.lu_ready !== 1'b0) begin failures++; $display("FAIL full_lu_ready got=%0b exp=0", bus.lu_ready); end
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd1) begin failures++; $display("FAIL full_wb_write got=%0b/%0d exp=1/1", bus.rf_we, bus.rf_waddr); end
    checks++; if (bus.pipe_hold !== 1'b0) begin failures++; $display("FAIL full_hold_edge1 got=%0b exp=0", bus.pipe_hold); end
    for (int n = 2; n <= int'(STARVE_MAX) - 1; n++) begin
      step();
      exp_hold = (n == int'(STARVE_MAX) - 1);
      checks++; if (bus.pipe_hold !== exp_hold) begin failures++; $display("FAIL full_hold_edge%0d got=%0b exp=%0b", n, bus.pipe_hold, exp_hold); end
    end
    bus.wb_valid = 1'b0;
    step();
    checks++; if (bus.pipe_hold !== 1'b0) begin failures++; $display("FAIL full_hold_drop got=%0b exp=0", bus.pipe_hold); end
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd10 || bus.rf_wdata !== 32'h1010)
      begin failures++; $display("FAIL full_oldest got=%0b/%0d/%h exp=1/10/1010", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (bus.lu_ready !== 1'b1) begin failures++; $display("FAIL full_ready_back got=%0b exp=1", bus.lu_ready); end
    step();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd11 || bus.rf_wdata !== 32'h1111)
      begin failures++; $display("FAIL full_second got=%0b/%0d/%h exp=1/11/1111", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    step();
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL full_drained got=%0b exp=0", bus.rf_we); end
  endtask

  task automatic test_r0_race();
    bus.issue_set = 1'b1;
    bus.issue_rd  = 5'd9;
    step();
    bus.issue_set = 1'b0;
    bus.lu_valid  = 1'b1;
    bus.lu_rd     = 5'd0;
    bus.lu_data   = 32'h55;
    step();
    bus.lu_rd   = 5'd9;
    bus.lu_data = 32'h99;
    step();  // r0 head granted and popped, rd9 pushed
    bus.lu_valid = 1'b0;
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL r0_suppressed got=%0b exp=0", bus.rf_we); end
    checks++; if (bus.pend !== 32'h0000_0200) begin failures++; $display("FAIL r0_pend got=%h exp=00000200", bus.pend); end
    bus.issue_set = 1'b1;
    bus.issue_rd  = 5'd9;
    step();  // rd9 granted while rd9 re-issued
    bus.issue_set = 1'b0;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9 || bus.rf_wdata !== 32'h99)
      begin failures++; $display("FAIL race_write got=%0b/%0d/%h exp=1/9/99", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (bus.pend !== 32'h0000_0200) begin failures++; $display("FAIL race_set_wins got=%h exp=00000200", bus.pend); end
    bus.issue_set = 1'b1;
    bus.issue_rd  = 5'd0;
    step();
    bus.issue_set = 1'b0;
    checks++; if (bus.pend !== 32'h0000_0200) begin failures++; $display("FAIL pend_r0 got=%h exp=00000200", bus.pend); end
  endtask

  task automatic test_mid_reset();
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 5'd2;
    bus.wb_data   = 32'h2;
    bus.lu_valid  = 1'b1;
    bus.lu_rd     = 5'd20;
    bus.lu_data   = 32'h2020;
    bus.issue_set = 1'b1;
    bus.issue_rd  = 5'd20;
    step();
    bus.issue_set = 1'b0;
    bus.lu_rd     = 5'd21;
    bus.lu_data   = 32'h2121;
    step();
    checks++; if (bus.pend !== 32'h0010_0200) begin failures++; $display("FAIL mid_pend_before got=%h exp=00100200", bus.pend); end
    idle_inputs();
    rst_n = 1'b0;
    step();
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL mid_rst_rf_we got=%0b exp=0", bus.rf_we); end
    checks++; if (bus.pend !== 32'h0) begin failures++; $display("FAIL mid_rst_pend got=%h exp=0", bus.pend); end
    checks++; if (bus.lu_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_lu_ready got=%0b exp=0", bus.lu_ready); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL mid_after1_rf_we got=%0b exp=0", bus.rf_we); end
    checks++; if (bus.lu_ready !== 1'b1) begin failures++; $display("FAIL mid_after_lu_ready got=%0b exp=1", bus.lu_ready); end
    bus.lu_valid = 1'b1;
    bus.lu_rd    = 5'd22;
    bus.lu_data  = 32'h2222;
    step();
    bus.lu_valid = 1'b0;
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL mid_after2_rf_we got=%0b exp=0", bus.rf_we); end
    step();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd22 || bus.rf_wdata !== 32'h2222)
      begin failures++; $display("FAIL mid_fresh_head got=%0b/%0d/%h exp=1/22/2222", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_r0_race();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
